bira_engine: RTL and testbench

Parametrised successor to the fixed-size BIRA top. It collects BIST fault reports into pivot and non-pivot CAMs and checks each bank against its own spare budget, raising early termination as soon as a bank cannot be repaired. After `test_end` it exhaustively searches row/column assignments for the stored pivots. On success it streams the repair solution out over a valid/ready handshake. It sits between the BIST controller and the fuse/repair-register loader.

---
 rtl/bira_pkg.sv | 42 ++++
 rtl/bira_assign_checker.sv | 55 +++++
 rtl/bira_engine.sv | 250 +++++++++++++++++++++++++
 tb/tb_bira_engine.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bira_pkg.sv
// Shared types and constants for the BIRA engine: FSM states, entry
// structs, solution-word layout and its packing helper.
package bira_pkg;

  localparam int ROW_W_P  = 10;
  localparam int COL_W_P  = 10;
  localparam int BANK_W_P = 2;
  localparam int ADDR_W   = (ROW_W_P > COL_W_P) ? ROW_W_P : COL_W_P;
  localparam int SOL_W    = 1 + BANK_W_P + ADDR_W;

  // Solution word layout: {is_col, bank, addr}
  localparam int SOL_ADDR_LSB = 0;
  localparam int SOL_BANK_LSB = ADDR_W;
  localparam int SOL_COL_BIT  = ADDR_W + BANK_W_P;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_EMIT    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic [BANK_W_P-1:0] bank;
    logic [ROW_W_P-1:0]  row;
    logic [COL_W_P-1:0]  col;
  } pivot_t;

  typedef struct packed {
    logic [BANK_W_P-1:0] bank;
    logic [ROW_W_P-1:0]  row;
    logic [COL_W_P-1:0]  col;
  } npivot_t;

  // Build one solution word; the chosen address is zero-extended to ADDR_W.
  function automatic logic [SOL_W-1:0] pack_sol(input logic is_col, input pivot_t p);
    logic [ADDR_W-1:0] addr;
    addr = is_col ? ADDR_W'(p.col) : ADDR_W'(p.row);
    return {is_col, p.bank, addr};
  endfunction

endpackage

// File: rtl/bira_assign_checker.sv
// Combinational check of one row/column assignment vector against the
// stored pivots and non-pivots: per-bank spare budgets plus coverage.
module bira_assign_checker
  import bira_pkg::*;
#(
  parameter int PCAM  = 8,
  parameter int NPCAM = 30,
  parameter int SPR   = 2,
  parameter int SPC   = 2
) (
  input  pivot_t             piv     [PCAM],
  input  logic [PCAM-1:0]    piv_vld,
  input  npivot_t            np      [NPCAM],
  input  logic [NPCAM-1:0]   np_vld,
  input  logic [PCAM-1:0]    vec,
  output logic               pass
);

  localparam int NUM_BANK = 1 << BANK_W_P;

  // Invalid pivot slots are masked, so vector bits beyond pcnt never matter.
  always_comb begin
    int   rows;
    int   cols;
    logic covered;
    pass    = 1'b1;
    rows    = 0;
    cols    = 0;
    covered = 1'b0;
    for (int b = 0; b < NUM_BANK; b++) begin
      rows = 0;
      cols = 0;
      for (int i = 0; i < PCAM; i++) begin
        if (piv_vld[i] && (piv[i].bank == BANK_W_P'(b))) begin
          if (vec[i]) cols = cols + 1;
          else        rows = rows + 1;
        end
      end
      if ((rows > SPR) || (cols > SPC)) pass = 1'b0;
    end
    for (int j = 0; j < NPCAM; j++) begin
      if (np_vld[j]) begin
        covered = 1'b0;
        for (int i = 0; i < PCAM; i++) begin
          if (piv_vld[i] && (piv[i].bank == np[j].bank) &&
              ((!vec[i] && (piv[i].row == np[j].row)) ||
               ( vec[i] && (piv[i].col == np[j].col))))
            covered = 1'b1;
        end
        if (!covered) pass = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bira_engine.sv
// BIRA engine: collects fault reports into pivot/non-pivot CAMs, flags
// early termination, searches assignments after test_end and streams the
// repair solution.
//
// Solution handshake: a word transfers on a cycle where sol_valid && sol_ready.
// sol_valid only drops after a transfer, sol_data/sol_last hold while
// sol_ready is low, and the next word appears the cycle after a transfer.
module bira_engine
  import bira_pkg::*;
#(
  parameter int ROW_W  = ROW_W_P,
  parameter int COL_W  = COL_W_P,
  parameter int BANK_W = BANK_W_P,
  parameter int PCAM   = 8,
  parameter int NPCAM  = 30,
  parameter int SPR    = 2,
  parameter int SPC    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fault_detect,
  input  logic [ROW_W-1:0]         row_add_in,
  input  logic [COL_W-1:0]         col_add_in,
  input  logic [BANK_W-1:0]        bank_in,
  input  logic                     test_end,
  output logic                     early_term,
  output logic                     done,
  output logic                     repair,
  output logic                     sol_valid,
  input  logic                     sol_ready,
  output logic [BANK_W+ADDR_W:0]   sol_data,
  output logic                     sol_last,
  output logic [1:0]               dbg_state
);

  localparam int CNT_W   = $clog2(PCAM + 1);
  localparam int NPCNT_W = $clog2(NPCAM + 1);
  localparam int PIDX_W  = (PCAM > 1) ? $clog2(PCAM) : 1;
  localparam int NPIDX_W = (NPCAM > 1) ? $clog2(NPCAM) : 1;
  localparam logic [CNT_W-1:0]   PCAM_C  = CNT_W'(PCAM);
  localparam logic [NPCNT_W-1:0] NPCAM_C = NPCNT_W'(NPCAM);

  state_t               state_q, state_d;
  pivot_t               pivot_q [PCAM];
  pivot_t               pivot_d [PCAM];
  npivot_t              np_q    [NPCAM];
  npivot_t              np_d    [NPCAM];
  logic [PCAM-1:0]      pvld_q, pvld_d;
  logic [NPCAM-1:0]     npvld_q, npvld_d;
  logic [CNT_W-1:0]     pcnt_q, pcnt_d;
  logic [NPCNT_W-1:0]   npcnt_q, npcnt_d;
  logic [PCAM-1:0]      vec_q, vec_d;
  logic [CNT_W-1:0]     ptr_q, ptr_d;
  logic                 early_term_q, early_term_d;
  logic                 done_q, done_d;
  logic                 repair_q, repair_d;
  logic                 sol_valid_q, sol_valid_d;
  logic [SOL_W-1:0]     sol_data_q, sol_data_d;
  logic                 sol_last_q, sol_last_d;

  pivot_t               new_p;
  npivot_t              new_np;
  logic                 dup, pmatch, pass;
  int                   bank_cnt;
  logic [PCAM:0]        span;
  logic                 last_vec;
  logic [CNT_W-1:0]     ptr_nxt;
  logic [PIDX_W-1:0]    nidx;

  assign new_p   = pivot_t'{bank: bank_in, row: row_add_in, col: col_add_in};
  assign new_np  = npivot_t'{bank: bank_in, row: row_add_in, col: col_add_in};
  assign span    = ({{PCAM{1'b0}}, 1'b1} << pcnt_q) - 1'b1;
  assign last_vec = (vec_q == span[PCAM-1:0]);
  assign ptr_nxt = ptr_q + CNT_W'(1);
  assign nidx    = ptr_nxt[PIDX_W-1:0];

  bira_assign_checker #(
    .PCAM (PCAM),
    .NPCAM(NPCAM),
    .SPR  (SPR),
    .SPC  (SPC)
  ) u_checker (
    .piv    (pivot_q),
    .piv_vld(pvld_q),
    .np     (np_q),
    .np_vld (npvld_q),
    .vec    (vec_q),
    .pass   (pass)
  );

  // CAM lookup of the incoming fault: duplicate, pivot match, bank occupancy.
  always_comb begin
    dup      = 1'b0;
    pmatch   = 1'b0;
    bank_cnt = 0;
    for (int i = 0; i < PCAM; i++) begin
      if (pvld_q[i]) begin
        if (pivot_q[i] == new_p) dup = 1'b1;
        if (pivot_q[i].bank == bank_in) begin
          bank_cnt = bank_cnt + 1;
          if ((pivot_q[i].row == row_add_in) || (pivot_q[i].col == col_add_in))
            pmatch = 1'b1;
        end
      end
    end
    for (int j = 0; j < NPCAM; j++) begin
      if (npvld_q[j] && (np_q[j] == new_np)) dup = 1'b1;
    end
  end

  // Next-state logic for the FSM, CAM writes, search counter and emit pointer.
  always_comb begin
    logic et_now;
    state_d      = state_q;
    pivot_d      = pivot_q;
    np_d         = np_q;
    pvld_d       = pvld_q;
    npvld_d      = npvld_q;
    pcnt_d       = pcnt_q;
    npcnt_d      = npcnt_q;
    vec_d        = vec_q;
    ptr_d        = ptr_q;
    early_term_d = early_term_q;
    done_d       = done_q;
    repair_d     = repair_q;
    sol_valid_d  = sol_valid_q;
    sol_data_d   = sol_data_q;
    sol_last_d   = sol_last_q;
    et_now       = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (fault_detect && !dup) begin
          if (pmatch) begin
            if (npcnt_q == NPCAM_C) begin
              et_now = 1'b1;
            end else begin
              np_d[npcnt_q[NPIDX_W-1:0]]    = new_np;
              npvld_d[npcnt_q[NPIDX_W-1:0]] = 1'b1;
              npcnt_d = npcnt_q + NPCNT_W'(1);
            end
          end else begin
            if ((bank_cnt >= SPR + SPC) || (pcnt_q == PCAM_C)) begin
              et_now = 1'b1;
            end else begin
              pivot_d[pcnt_q[PIDX_W-1:0]] = new_p;
              pvld_d[pcnt_q[PIDX_W-1:0]]  = 1'b1;
              pcnt_d = pcnt_q + CNT_W'(1);
            end
          end
        end
        // A fault arriving with test_end is classified before the decision.
        if (et_now) begin
          early_term_d = 1'b1;
          done_d       = 1'b1;
          repair_d     = 1'b0;
          state_d      = ST_DONE;
        end else if (test_end) begin
          if (pcnt_d == '0) begin
            done_d   = 1'b1;
            repair_d = 1'b1;
            state_d  = ST_DONE;
          end else begin
            vec_d   = '0;
            state_d = ST_SEARCH;
          end
        end
      end
      ST_SEARCH: begin
        if (pass) begin
          ptr_d       = '0;
          sol_valid_d = 1'b1;
          sol_data_d  = pack_sol(vec_q[0], pivot_q[0]);
          sol_last_d  = (pcnt_q == CNT_W'(1));
          state_d     = ST_EMIT;
        end else if (last_vec) begin
          done_d   = 1'b1;
          repair_d = 1'b0;
          state_d  = ST_DONE;
        end else begin
          vec_d = vec_q + PCAM'(1);
        end
      end
      ST_EMIT: begin
        if (sol_valid_q && sol_ready) begin
          if (sol_last_q) begin
            sol_valid_d = 1'b0;
            sol_data_d  = '0;
            sol_last_d  = 1'b0;
            done_d      = 1'b1;
            repair_d    = 1'b1;
            state_d     = ST_DONE;
          end else begin
            ptr_d      = ptr_nxt;
            sol_data_d = pack_sol(vec_q[nidx], pivot_q[nidx]);
            sol_last_d = (ptr_nxt == (pcnt_q - CNT_W'(1)));
          end
        end
      end
      default: begin
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      for (int i = 0; i < PCAM; i++)  pivot_q[i] <= '0;
      for (int j = 0; j < NPCAM; j++) np_q[j]    <= '0;
      pvld_q       <= '0;
      npvld_q      <= '0;
      pcnt_q       <= '0;
      npcnt_q      <= '0;
      vec_q        <= '0;
      ptr_q        <= '0;
      early_term_q <= 1'b0;
      done_q       <= 1'b0;
      repair_q     <= 1'b0;
      sol_valid_q  <= 1'b0;
      sol_data_q   <= '0;
      sol_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pivot_q      <= pivot_d;
      np_q         <= np_d;
      pvld_q       <= pvld_d;
      npvld_q      <= npvld_d;
      pcnt_q       <= pcnt_d;
      npcnt_q      <= npcnt_d;
      vec_q        <= vec_d;
      ptr_q        <= ptr_d;
      early_term_q <= early_term_d;
      done_q       <= done_d;
      repair_q     <= repair_d;
      sol_valid_q  <= sol_valid_d;
      sol_data_q   <= sol_data_d;
      sol_last_q   <= sol_last_d;
    end
  end

  assign early_term = early_term_q;
  assign done       = done_q;
  assign repair     = repair_q;
  assign sol_valid  = sol_valid_q;
  assign sol_data   = sol_data_q;
  assign sol_last   = sol_last_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bira_engine.sv
// Directed plus randomized bench for bira_engine with a queue-based
// reference model of fault classification and repair search.
module tb_bira_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        fault_detect;
  logic [9:0]  row_add_in;
  logic [9:0]  col_add_in;
  logic [1:0]  bank_in;
  logic        test_end;
  logic        early_term;
  logic        done;
  logic        repair;
  logic        sol_valid;
  logic        sol_ready;
  logic [12:0] sol_data;
  logic        sol_last;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  // Reference model storage
  int p_r[$];
  int p_c[$];
  int p_b[$];
  int n_r[$];
  int n_c[$];
  int n_b[$];
  bit m_et;

  bira_engine dut (
    .clk         (clk),
    .rst         (rst),
    .fault_detect(fault_detect),
    .row_add_in  (row_add_in),
    .col_add_in  (col_add_in),
    .bank_in     (bank_in),
    .test_end    (test_end),
    .early_term  (early_term),
    .done        (done),
    .repair      (repair),
    .sol_valid   (sol_valid),
    .sol_ready   (sol_ready),
    .sol_data    (sol_data),
    .sol_last    (sol_last),
    .dbg_state   (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Safety net against a hung run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    p_r.delete(); p_c.delete(); p_b.delete();
    n_r.delete(); n_c.delete(); n_b.delete();
    m_et = 1'b0;
  endfunction

  function automatic void model_fault(input int r, input int c, input int b);
    bit dup = 0;
    bit pm  = 0;
    int bc  = 0;
    if (m_et) return;
    foreach (p_r[i]) begin
      if (p_b[i] == b) begin
        bc++;
        if (p_r[i] == r && p_c[i] == c) dup = 1;
        if (p_r[i] == r || p_c[i] == c) pm = 1;
      end
    end
    foreach (n_r[j])
      if (n_b[j] == b && n_r[j] == r && n_c[j] == c) dup = 1;
    if (dup) return;
    if (pm) begin
      if (n_r.size() == 30) m_et = 1;
      else begin n_r.push_back(r); n_c.push_back(c); n_b.push_back(b); end
    end else begin
      if (bc >= 4 || p_r.size() == 8) m_et = 1;
      else begin p_r.push_back(r); p_c.push_back(c); p_b.push_back(b); end
    end
  endfunction

  // Does assignment v (bit i = column for pivot i) repair every bank?
  function automatic bit vec_ok(input int v);
    for (int b = 0; b < 4; b++) begin
      int rows = 0;
      int cols = 0;
      foreach (p_r[i])
        if (p_b[i] == b) begin
          if ((v >> i) & 1) cols++;
          else rows++;
        end
      if (rows > 2 || cols > 2) return 0;
    end
    foreach (n_r[j]) begin
      bit cov = 0;
      foreach (p_r[i])
        if (p_b[i] == n_b[j]) begin
          if (((v >> i) & 1) && p_c[i] == n_c[j]) cov = 1;
          if (!((v >> i) & 1) && p_r[i] == n_r[j]) cov = 1;
        end
      if (!cov) return 0;
    end
    return 1;
  endfunction

  function automatic void model_search(output bit found, output int vec);
    found = 0;
    vec   = 0;
    for (int v = 0; v < (1 << p_r.size()); v++) begin
      if (!found && vec_ok(v)) begin
        found = 1;
        vec   = v;
      end
    end
  endfunction

  // Ends on a negedge with reset released and the model cleared.
  task automatic do_reset();
    rst = 1; fault_detect = 0; test_end = 0; sol_ready = 0;
    row_add_in = '0; col_add_in = '0; bank_in = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  task automatic send_fault(input int r, input int c, input int b, input bit te);
    row_add_in   = r[9:0];
    col_add_in   = c[9:0];
    bank_in      = b[1:0];
    fault_detect = 1;
    test_end     = te;
    @(negedge clk);
    fault_detect = 0;
    test_end     = 0;
    model_fault(r, c, b);
    check("early_term", early_term, m_et);
    check("done_after_fault", done, m_et);
  endtask

  task automatic run_analysis(input int stall, input bit pulse);
    bit found;
    int vec;
    int n;
    int exp_k;
    int k;
    n = p_r.size();
    if (pulse) begin
      test_end = 1;
      @(negedge clk);
      test_end = 0;
    end
    if (m_et) begin
      repeat (3) begin
        check("et_no_valid", sol_valid, 0);
        @(negedge clk);
      end
      check("et_done", done, 1);
      check("et_repair", repair, 0);
      check("et_sticky", early_term, 1);
      return;
    end
    model_search(found, vec);
    exp_k = (n == 0) ? 0 : (found ? vec + 1 : (1 << n));
    k = 0;
    while (!(sol_valid === 1'b1 || done === 1'b1) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, exp_k);
    if (n == 0 || !found) begin
      check("nf_done", done, 1);
      check("nf_repair", repair, (n == 0) ? 1 : 0);
      check("nf_valid", sol_valid, 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      int bit_i;
      int exp_w;
      int waited;
      bit took;
      bit_i  = (vec >> i) & 1;
      exp_w  = (bit_i << 12) | (p_b[i] << 10) | (bit_i ? p_c[i] : p_r[i]);
      waited = 0;
      took   = 0;
      while (!took) begin
        check("sol_valid", sol_valid, 1);
        check("sol_data", sol_data, exp_w);
        check("sol_last", sol_last, (i == n - 1) ? 1 : 0);
        check("done_in_emit", done, 0);
        if (i == 0 && waited < stall) sol_ready = 0;
        else if (waited >= 3)         sol_ready = 1;
        else                          sol_ready = 1'($urandom_range(0, 1));
        took = sol_ready;
        waited++;
        @(negedge clk);
      end
    end
    sol_ready = 0;
    check("end_valid", sol_valid, 0);
    check("end_done", done, 1);
    check("end_repair", repair, 1);
    check("end_last", sol_last, 0);
  endtask

  initial begin
    model_clear();
    do_reset();

    // Reset values
    check("rst_early_term", early_term, 0);
    check("rst_done", done, 0);
    check("rst_repair", repair, 0);
    check("rst_sol_valid", sol_valid, 0);
    check("rst_sol_data", sol_data, 0);
    check("rst_sol_last", sol_last, 0);
    check("rst_state", dbg_state, 0);

    // Single fault
    send_fault(5, 7, 1, 0);
    run_analysis(0, 1);

    // Shared row
    do_reset();
    send_fault(3, 1, 0, 0);
    send_fault(3, 2, 0, 0);
    send_fault(3, 3, 0, 0);
    run_analysis(0, 1);

    // Pivot overflow in one bank
    do_reset();
    for (int i = 0; i < 5; i++) send_fault(i, i, 2, 0);
    run_analysis(0, 1);

    // Unrepairable
    do_reset();
    send_fault(0, 0, 0, 0); send_fault(1, 1, 0, 0); send_fault(2, 2, 0, 0);
    send_fault(10, 0, 0, 0); send_fault(11, 1, 0, 0); send_fault(12, 2, 0, 0);
    run_analysis(0, 1);

    // Backpressure
    do_reset();
    send_fault(4, 4, 0, 0);
    send_fault(5, 5, 0, 0);
    run_analysis(5, 1);

    // No faults at all
    do_reset();
    run_analysis(0, 1);

    // Fault arriving together with test_end
    do_reset();
    send_fault(9, 9, 3, 1);
    run_analysis(0, 0);

    // Pivot CAM full across banks
    do_reset();
    for (int i = 0; i < 9; i++) send_fault(i, i, i % 4, 0);
    run_analysis(0, 1);

    // Non-pivot CAM full
    do_reset();
    send_fault(0, 0, 0, 0);
    for (int c = 1; c <= 31; c++) send_fault(0, c, 0, 0);
    run_analysis(0, 1);

    // Mid-search reset
    do_reset();
    send_fault(0, 0, 0, 0); send_fault(1, 1, 0, 0); send_fault(2, 2, 0, 0);
    send_fault(10, 0, 0, 0); send_fault(11, 1, 0, 0); send_fault(12, 2, 0, 0);
    test_end = 1;
    @(negedge clk);
    test_end = 0;
    repeat (3) @(negedge clk);
    check("mid_state_search", dbg_state, 1);
    check("mid_done", done, 0);
    rst = 1;
    @(negedge clk);
    check("mr_early_term", early_term, 0);
    check("mr_done", done, 0);
    check("mr_repair", repair, 0);
    check("mr_sol_valid", sol_valid, 0);
    check("mr_sol_data", sol_data, 0);
    check("mr_sol_last", sol_last, 0);
    check("mr_state", dbg_state, 0);
    rst = 0;
    model_clear();
    send_fault(5, 7, 1, 0);
    run_analysis(0, 1);

    // Randomized scenarios with small address ranges to provoke matches
    for (int t = 0; t < 25; t++) begin
      int nf;
      do_reset();
      nf = $urandom_range(1, 10);
      for (int f = 0; f < nf; f++) begin
        send_fault($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), 0);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      run_analysis($urandom_range(0, 3), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
